// File: rtl/rename_reg_file.sv
// rename_reg_file: merged architectural map and physical rename file.
// The block keeps a busy bit, a current tag and committed data for each
// architectural register. It also keeps a valid bit and data for each
// physical tag. A circular free list hands out DISPATCH_W tags per cycle.
// Ports:
//   clk, reset (sync, active-low), flush (active-high)
//   alloc_req/alloc_arch_idx    -> alloc_ready/alloc_tag/free_count  rename
//   wb_en/wb_tag/wb_data        execute writeback
//   commit_valid/commit_arch_idx/commit_tag   ROB retire
//   map_busy/map_tag/arch_data/phys_valid/phys_data   per-register read view
//   fl_error                    sticky free-list overflow/underflow
// Optional macro RENAME_RF_WB_BYPASS_EN: forwards same-cycle writeback data
// to phys_valid/phys_data and to commit data.
module rename_reg_file #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ARCH_N     = 8,
  parameter int unsigned PHYS_N     = 128,
  parameter int unsigned TAG_W      = $clog2(PHYS_N),
  parameter int unsigned DISPATCH_W = 2,
  parameter int unsigned WB_N       = 3,
  parameter int unsigned COMMIT_W   = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [DISPATCH_W-1:0]           alloc_req,
  input  logic [DISPATCH_W*$clog2(ARCH_N)-1:0] alloc_arch_idx,
  output logic                            alloc_ready,
  output logic [DISPATCH_W*TAG_W-1:0]     alloc_tag,
  output logic [$clog2(PHYS_N):0]         free_count,
  input  logic [WB_N-1:0]                 wb_en,
  input  logic [WB_N*TAG_W-1:0]           wb_tag,
  input  logic [WB_N*DATA_W-1:0]          wb_data,
  input  logic [COMMIT_W-1:0]             commit_valid,
  input  logic [COMMIT_W*$clog2(ARCH_N)-1:0] commit_arch_idx,
  input  logic [COMMIT_W*TAG_W-1:0]       commit_tag,
  output logic [ARCH_N-1:0]               map_busy,
  output logic [ARCH_N*TAG_W-1:0]         map_tag,
  output logic [ARCH_N*DATA_W-1:0]        arch_data,
  output logic [ARCH_N-1:0]               phys_valid,
  output logic [ARCH_N*DATA_W-1:0]        phys_data,
  output logic                            fl_error
);

  localparam int unsigned AW = $clog2(ARCH_N);
  localparam int unsigned CW = $clog2(PHYS_N) + 1;

  logic [ARCH_N-1:0]  r_busy, n_busy;
  logic [TAG_W-1:0]   r_map  [ARCH_N];
  logic [TAG_W-1:0]   n_map  [ARCH_N];
  logic [DATA_W-1:0]  r_arch [ARCH_N];
  logic [DATA_W-1:0]  n_arch [ARCH_N];
  logic [PHYS_N-1:0]  r_pv, n_pv;
  logic [DATA_W-1:0]  r_pd   [PHYS_N];
  logic [DATA_W-1:0]  n_pd   [PHYS_N];
  logic [TAG_W-1:0]   r_fl   [PHYS_N];
  logic [TAG_W-1:0]   n_fl   [PHYS_N];
  logic [TAG_W-1:0]   r_head, n_head, r_tail, n_tail;
  logic [CW-1:0]      r_count, n_count;
  logic               r_err, n_err;
  logic               w_alloc_ready;

  assign w_alloc_ready = (r_count >= CW'(DISPATCH_W));
  assign alloc_ready   = w_alloc_ready;
  assign free_count    = r_count;
  assign fl_error      = r_err;
  assign map_busy      = r_busy;

  always_comb begin
    logic [TAG_W-1:0] v_t;
    v_t         = '0;
    alloc_tag   = '0;
    map_tag     = '0;
    arch_data   = '0;
    phys_valid  = '0;
    phys_data   = '0;
    for (int unsigned i = 0; i < DISPATCH_W; i++)
      alloc_tag[i*TAG_W +: TAG_W] = r_fl[r_head + TAG_W'(i)];
    for (int unsigned r = 0; r < ARCH_N; r++) begin
      v_t = r_map[r];
      map_tag[r*TAG_W +: TAG_W]    = v_t;
      arch_data[r*DATA_W +: DATA_W] = r_arch[r];
      phys_valid[r]                 = r_pv[v_t];
      phys_data[r*DATA_W +: DATA_W] = r_pd[v_t];
`ifdef RENAME_RF_WB_BYPASS_EN
      for (int unsigned k = 0; k < WB_N; k++) begin
        if (wb_en[k] && (wb_tag[k*TAG_W +: TAG_W] == v_t)) begin
          phys_valid[r]                 = 1'b1;
          phys_data[r*DATA_W +: DATA_W] = wb_data[k*DATA_W +: DATA_W];
        end
      end
`endif
    end
  end

  // Updates are applied in a fixed order so that the later step wins:
  // writeback, commit clears, rename sets, and then free-list pushes.
  // Pops are counted before pushes so that overflow is judged on the
  // post-pop occupancy.
  always_comb begin
    logic [TAG_W-1:0]  v_t;
    logic [AW-1:0]     v_a;
    logic [DATA_W-1:0] v_d;
    logic [CW-1:0]     v_cnt;
    v_t     = '0;
    v_a     = '0;
    v_d     = '0;
    v_cnt   = r_count;
    n_busy  = r_busy;
    n_map   = r_map;
    n_arch  = r_arch;
    n_pv    = r_pv;
    n_pd    = r_pd;
    n_fl    = r_fl;
    n_head  = r_head;
    n_tail  = r_tail;
    n_count = r_count;
    n_err   = r_err;

    for (int unsigned j = 0; j < COMMIT_W; j++) begin
      if (commit_valid[j]) begin
        v_t = commit_tag[j*TAG_W +: TAG_W];
        v_a = commit_arch_idx[j*AW +: AW];
        v_d = r_pd[v_t];
`ifdef RENAME_RF_WB_BYPASS_EN
        for (int unsigned k = 0; k < WB_N; k++)
          if (wb_en[k] && (wb_tag[k*TAG_W +: TAG_W] == v_t))
            v_d = wb_data[k*DATA_W +: DATA_W];
`endif
        n_arch[v_a] = v_d;
      end
    end

    if (flush) begin
      n_busy = '0;
      n_pv   = '0;
      for (int unsigned i = 0; i < ARCH_N; i++) n_map[i] = '0;
      for (int unsigned p = 0; p < PHYS_N; p++) n_fl[p] = TAG_W'(p);
      n_head  = '0;
      n_tail  = '0;
      n_count = CW'(PHYS_N);
    end else begin
      for (int unsigned k = 0; k < WB_N; k++) begin
        if (wb_en[k]) begin
          v_t       = wb_tag[k*TAG_W +: TAG_W];
          n_pd[v_t] = wb_data[k*DATA_W +: DATA_W];
          n_pv[v_t] = 1'b1;
        end
      end
      for (int unsigned j = 0; j < COMMIT_W; j++) begin
        if (commit_valid[j]) begin
          v_t       = commit_tag[j*TAG_W +: TAG_W];
          v_a       = commit_arch_idx[j*AW +: AW];
          n_pv[v_t] = 1'b0;
          if (r_map[v_a] == v_t) n_busy[v_a] = 1'b0;
        end
      end
      if (|alloc_req) begin
        if (w_alloc_ready) begin
          for (int unsigned i = 0; i < DISPATCH_W; i++) begin
            if (alloc_req[i]) begin
              v_t         = r_fl[r_head + TAG_W'(i)];
              v_a         = alloc_arch_idx[i*AW +: AW];
              n_pv[v_t]   = 1'b0;
              n_busy[v_a] = 1'b1;
              n_map[v_a]  = v_t;
              n_head      = n_head + TAG_W'(1);
              v_cnt       = v_cnt - CW'(1);
            end
          end
        end else begin
          n_err = 1'b1;
        end
      end
      for (int unsigned j = 0; j < COMMIT_W; j++) begin
        if (commit_valid[j]) begin
          if (v_cnt < CW'(PHYS_N)) begin
            n_fl[n_tail] = commit_tag[j*TAG_W +: TAG_W];
            n_tail       = n_tail + TAG_W'(1);
            v_cnt        = v_cnt + CW'(1);
          end else begin
            n_err = 1'b1;
          end
        end
      end
      n_count = v_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy <= '0;
      r_pv   <= '0;
      for (int unsigned i = 0; i < ARCH_N; i++) begin
        r_map[i]  <= '0;
        r_arch[i] <= '0;
      end
      for (int unsigned p = 0; p < PHYS_N; p++) begin
        r_pd[p] <= '0;
        r_fl[p] <= TAG_W'(p);
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= CW'(PHYS_N);
      r_err   <= 1'b0;
    end else begin
      r_busy  <= n_busy;
      r_map   <= n_map;
      r_arch  <= n_arch;
      r_pv    <= n_pv;
      r_pd    <= n_pd;
      r_fl    <= n_fl;
      r_head  <= n_head;
      r_tail  <= n_tail;
      r_count <= n_count;
      r_err   <= n_err;
    end
  end

endmodule

// File: doc/rename_reg_file.md
# rename_reg_file

Parametrised successor to the split architectural/rename register pair. It merges the architectural map (busy, tag, committed data per architectural register) and the physical rename file (valid, data per tag) into one block. The priority-scan empty-slot search is replaced by a FIFO free list that allocates N tags per cycle, and the widths and port counts are generic. It sits between decode/dispatch (rename and operand read), the execute writeback buses, and ROB commit.

## Interface
Parameters:
- DATA_W, 16, data width
- ARCH_N, 8, architectural registers
- PHYS_N, 128, physical registers (power of two, > DISPATCH_W)
- TAG_W, $clog2(PHYS_N), tag width
- DISPATCH_W, 2, rename slots per cycle
- WB_N, 3, writeback ports
- COMMIT_W, 2, commit ports

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- flush  in  1  pipeline flush, active-high
- alloc_req  in  DISPATCH_W  rename request per slot; set bits must be contiguous from bit 0
- alloc_arch_idx  in  DISPATCH_W*$clog2(ARCH_N)  destination architectural register per slot
- alloc_ready  out  1  free_count >= DISPATCH_W
- alloc_tag  out  DISPATCH_W*TAG_W  tag granted to slot i = free-list entry head+i
- free_count  out  $clog2(PHYS_N)+1  entries currently in the free list
- wb_en  in  WB_N  writeback strobe
- wb_tag  in  WB_N*TAG_W  writeback tag
- wb_data  in  WB_N*DATA_W  writeback data
- commit_valid  in  COMMIT_W  retire strobe
- commit_arch_idx  in  COMMIT_W*$clog2(ARCH_N)  retiring destination
- commit_tag  in  COMMIT_W*TAG_W  retiring tag
- map_busy  out  ARCH_N  per-register rename-pending bit
- map_tag  out  ARCH_N*TAG_W  current tag per architectural register
- arch_data  out  ARCH_N*DATA_W  committed data
- phys_valid  out  ARCH_N  valid bit of the physical entry at map_tag[r]
- phys_data  out  ARCH_N*DATA_W  data of the physical entry at map_tag[r]
- fl_error  out  1  sticky: free-list overflow or underflow attempted

## Operation
- Reset (reset==0): all map_busy and map_tag cleared to 0. arch_data, phys data and phys valid cleared to 0. Free list holds 0..PHYS_N-1 in order, head=tail=0, free_count=PHYS_N. fl_error cleared. Hence alloc_ready=1 and alloc_tag[i]=i.
- Allocation: each slot i with alloc_req[i]&alloc_ready pops one tag. That tag's valid is cleared, map_busy[arch]=1 and map_tag[arch]=alloc_tag[i]. If alloc_req!=0 while alloc_ready=0, nothing is popped and fl_error is set.
- Writeback: wb_en[k] writes data[wb_tag[k]] and sets valid. Where ports share a tag, the higher k wins.
- Commit: commit_valid[j] performs four actions:
  - copies data[commit_tag[j]] to arch_data[commit_arch_idx[j]];
  - clears the tag's valid;
  - pushes the tag at the tail;
  - clears map_busy[arch] if map_tag[arch]==commit_tag[j].
- Commit ordering: the higher j wins for the same arch register. Committed tags join the free list in port order and are not allocatable in the same cycle.
- Simultaneous rename and commit of the same arch register: the rename wins, so busy stays 1 with the new tag. Among dispatch slots, the higher slot wins on the same arch register.
- free_count next = free_count - pops + pushes. A push that would exceed PHYS_N is dropped and sets fl_error.
- Flush (reset==1, flush==1):
  - all map_busy and map_tag cleared; all phys valid cleared;
  - free list reinitialised as at reset;
  - allocations and writebacks that cycle are ignored;
  - commits that cycle still update arch_data only;
  - arch_data is otherwise retained.
- Illegal inputs (the bench flags these): writeback to a tag that is on the free list, and commit of a tag whose valid==0.

## Timing
- All outputs except alloc_ready/alloc_tag/free_count are combinational reads of registered state. alloc_ready/alloc_tag/free_count are derived from the registered head/count.
- Writeback-to-read latency is 1 cycle (0 with bypass).
- Commit-to-arch_data latency is 1 cycle.
- Commit-to-reallocation latency is 1 cycle (the pushed tag is visible in free_count the next cycle).
- Allocation effect is visible on map_tag/map_busy the next cycle.
- Reset and flush take effect on the same edge. A reset asserted mid-operation discards all in-flight state.
- Head and tail pointers wrap modulo PHYS_N.

## Configuration
- RENAME_RF_WB_BYPASS_EN defined:
  - phys_valid[r]/phys_data[r] forward a same-cycle wb_en[k] whose wb_tag==map_tag[r]; the highest k wins.
  - commit also forwards same-cycle writeback data for its tag into arch_data.
- Not defined: reads see registered state only; writeback is visible one cycle later.

## Test plan
- Reset, then two allocations to R1 and R2 -> alloc_tag 0,1; next cycle map_tag[1]=0, map_tag[2]=1, busy=1, free_count=126.
- wb tag 0 = 16'hBEEF, then commit (R1, tag 0) -> arch_data[1]=BEEF, busy[1]=0 one cycle later; free_count returns +1; tag 0 is reissued after 127 further pops (wrap).
- Same cycle: rename R3 (slot 0) and commit R3's old tag -> busy[3] stays 1, map_tag[3] = new tag.
- Allocate until free_count=1 -> alloc_ready=0; a request sets fl_error and free_count is unchanged.
- Flush with one commit (R4, tag 5 holding 16'h1234) -> all busy=0, free_count=128, arch_data[4]=1234, other arch_data retained.
- With RENAME_RF_WB_BYPASS_EN, wb to map_tag[2] -> phys_valid[2]=1 and phys_data updated in the same cycle. Without it, the update appears next cycle.
